// File: rtl/uart_tx_port.sv
// CPU output port: a small FIFO fed by the OUT strobe, drained by an 8N1 serialiser.
// full/empty/busy are decoded from registered state only, so the CPU stall path stays clean.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [7:0]            din,
  output logic                  tx,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                       state;
  logic [DEPTH-1:0][7:0]        mem;
  logic [DEPTH_LOG2-1:0]        wptr, rptr;
  logic [BW-1:0]                bcnt;
  logic [2:0]                   bidx;
  logic [7:0]                   shift;
  logic                         do_wr, do_pop, bit_end;

  assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (level == '0);
  assign busy    = (state != IDLE) | ~empty;
  assign do_wr   = wr & ~full;
  assign do_pop  = (state == IDLE) & ~empty;
  assign bit_end = (bcnt == BW'(CLKS_PER_BIT - 1));

  // Storage is not reset; pointers and level alone define what is valid.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)      wptr     <= wptr + 1'b1;
      if (wr && full) overflow <= 1'b1;
      if (do_pop)     rptr     <= rptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // tx is registered: each transition sets the line value for the next bit period.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      tx    <= 1'b1;
      bcnt  <= '0;
      bidx  <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (do_pop) begin
            shift <= mem[rptr];
            bcnt  <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bcnt  <= '0;
            bidx  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bcnt <= '0;
            if (bidx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift <= shift >> 1;
              tx    <= shift[1];
              bidx  <= bidx + 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            bcnt  <= '0;
            state <= IDLE;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed writes push expected bytes; a line decoder pops and compares each frame.
module tb_uart_tx_port;
  localparam int CPB = 4;
  localparam int DL2 = 2;

  logic           CLK, rst, wr;
  logic [7:0]     din;
  logic           tx, full, empty, busy, overflow;
  logic [DL2:0]   level;

  uart_tx_port #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .CLK(CLK), .rst(rst), .wr(wr), .din(din), .tx(tx), .full(full),
    .empty(empty), .busy(busy), .level(level), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  int          cyc = 0;
  int          mcnt = -1;
  int          frames = 0;
  bit          mon_abort = 0;
  int          peak = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Line decoder: samples every negedge, data bits at mid-period (sample 6+4j), stop at 38.
  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] expb;
    bit         have;
    rx = '0; expb = '0; have = 0;
    forever begin
      @(negedge CLK);
      if (mon_abort) begin
        mcnt = -1;
        mon_abort = 0;
      end else if (mcnt < 0) begin
        if (tx === 1'b0) begin
          mcnt = 0;
          frames++;
          starts.push_back(cyc);
          if (exp_q.size() == 0) begin
            have = 0;
            chk("unexpected_frame", 1, 0);
          end else begin
            expb = exp_q.pop_front();
            have = 1;
          end
        end
      end else begin
        mcnt++;
        if (mcnt == 2) chk("start_bit", tx, 0);
        if (mcnt >= 6 && mcnt <= 34 && ((mcnt - 6) % CPB) == 0) rx = {tx, rx[7:1]};
        if (mcnt == 38) begin
          chk("stop_bit", tx, 1);
          if (have) chk("frame_byte", rx, expb);
        end
        if (mcnt == 10*CPB - 1) mcnt = -1;
      end
    end
  end

  // Called at posedge+1; leaves wr asserted so consecutive calls hit consecutive edges.
  task automatic put(input logic [7:0] d, input bit accept);
    wr = 1'b1;
    din = d;
    if (accept) exp_q.push_back(d);
    @(posedge CLK);
    #1;
    if (int'(level) > peak) peak = int'(level);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      #1;
      if (busy === 1'b0 && mcnt < 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    rst = 1'b0;
  endtask

  initial begin : stim
    int n, fr0;
    bit ok;
    rst = 1'b1; wr = 1'b0; din = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tx", tx, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge CLK); #1;
    rst = 1'b0;

    // single byte A5
    @(posedge CLK); #1;
    put(8'hA5, 1);
    wr = 1'b0;
    chk("single_empty", empty, 0);
    chk("single_busy", busy, 1);
    chk("single_level_pre", level, 1);
    @(posedge CLK); #1;
    chk("single_level_pop", level, 0);
    chk("single_tx_start", tx, 0);
    n = 1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      n++;
      if (busy === 1'b0) begin ok = 1; break; end
    end
    chk("single_busy_done", ok, 1);
    chk("single_busy_cycles", n, 41);
    wait_idle();

    // burst of four
    @(posedge CLK); #1;
    starts.delete();
    peak = 0;
    for (int i = 1; i <= 4; i++) put(8'(i), 1);
    wr = 1'b0;
    wait_idle();
    chk("burst_peak", peak, 3);
    chk("burst_overflow", overflow, 0);
    chk("burst_frames", starts.size(), 4);
    if (starts.size() == 4)
      for (int i = 1; i < 4; i++) chk("burst_spacing", starts[i] - starts[i-1], 41);

    // overflow: 0x15 dropped
    @(posedge CLK); #1;
    for (int i = 0; i < 6; i++) begin
      put(8'h10 + 8'(i), i < 5);
      if (i == 4) begin
        chk("ovf_full", full, 1);
        chk("ovf_pre", overflow, 0);
      end
    end
    wr = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 4);
    wait_idle();
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // pointer wrap: 30 in flight, 31..34 fill, then 35..38 fill again
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) put(8'h30 + 8'(i), 1);
    wr = 1'b0;
    chk("wrap_full1", full, 1);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      if (level == 0) begin ok = 1; break; end
    end
    chk("wrap_drain", ok, 1);
    for (int i = 5; i < 9; i++) put(8'h30 + 8'(i), 1);
    wr = 1'b0;
    chk("wrap_full2", full, 1);
    wait_idle();

    // reset during DATA bit 3 with two bytes queued
    @(posedge CLK); #1;
    put(8'h40, 1); put(8'h41, 1); put(8'h42, 1);
    wr = 1'b0;
    chk("rstmid_level", level, 2);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #1;
      if (mcnt == 17) begin ok = 1; break; end
    end
    chk("rstmid_reach_bit3", ok, 1);
    rst = 1'b1;
    exp_q.delete();
    mon_abort = 1;
    @(posedge CLK); #1;
    rst = 1'b0;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_level0", level, 0);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_busy", busy, 0);
    @(negedge CLK); #1;
    fr0 = frames;
    repeat (100) @(negedge CLK);
    chk("rstmid_no_frames", frames, fr0);
    @(posedge CLK); #1;
    put(8'h5A, 1);
    wr = 1'b0;
    wait_idle();

    // write on the same edge as a pop with level 2
    @(posedge CLK); #1;
    put(8'h50, 1); put(8'h51, 1); put(8'h52, 1);
    wr = 1'b0;
    repeat (39) @(posedge CLK);
    #1;
    chk("simul_level_pre", level, 2);
    put(8'h53, 1);
    wr = 1'b0;
    chk("simul_level_post", level, 2);
    chk("simul_tx_start", tx, 0);
    wait_idle();

    chk("leftover_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Output stage of the 8-bit CPU: captures the value driven onto the bus when the controller asserts OI (the OUT instruction) and serialises it as 8N1 UART frames on a single `tx` line. It sits downstream of the CPU in place of the plain result register. A small FIFO decouples instruction timing from line timing. `full` and `busy` let the CPU clock gate stall OUT until the byte has been accepted, or until the line is idle.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: CLK cycles per UART bit; legal range ≥ 2.
- DEPTH_LOG2, default 2: log2 of FIFO depth; default depth is 4 entries.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr  in  1  write strobe (CPU OI); sampled on CLK rising edge.
- din  in  8  byte to send (CPU bus); sampled with `wr`.
- tx  out  1  serial line; idle high; registered.
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  out  1  FIFO holds 0 entries.
- busy  out  1  `(state != IDLE) | ~empty`.
- level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky flag: a write was attempted while `full`.

## Operation
- FIFO is circular, with read and write pointers of width DEPTH_LOG2 that wrap modulo depth; `level` is a separate counter.
- Write: on an edge with `wr & ~full`, store `din` at the write pointer, then increment the pointer.
- Overflow: on an edge with `wr & full`, drop `din`, leave FIFO state unchanged, and set `overflow`. `overflow` clears only on rst.
- Pop: happens only in IDLE when `~empty`.
  - Load the head byte into an 8-bit shift register and advance the read pointer.
- Level update on each edge: +1 on write only, −1 on pop only, unchanged when both or neither occur.
- Flag evaluation: `full` and `empty` are taken from pre-edge state.
  - A write on the same edge as a pop from a full FIFO is still rejected and sets `overflow`.
- Transmitter FSM, with a bit-period counter `bcnt` (0..CLKS_PER_BIT−1) and a bit index `bidx` (0..7):
  - IDLE: `tx`=1. If `~empty`: pop, clear `bcnt`, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then clear `bidx` and go to DATA.
  - DATA: `tx` = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment `bidx`. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame is 10·CLKS_PER_BIT cycles of line time.
- Back-to-back frames are separated by exactly 1 IDLE cycle; the frame-start period is 10·CLKS_PER_BIT+1 cycles.
- Reset, including mid-frame, takes effect on the next edge:
  - state=IDLE, `tx`=1, pointers=0, `level`=0, `overflow`=0.
  - FIFO contents are discarded and any partial frame is abandoned.
- Reset values: `tx`=1, `full`=0, `empty`=1, `busy`=0, `level`=0, `overflow`=0.

## Timing
- `tx`, state, `bcnt`, `bidx`, pointers, `level` and `overflow` are registered.
- `full`, `empty` and `busy` are combinational decodes of registered state; they have no input-to-output combinational path.
- Latency: for `wr` at edge k into an idle, empty block:
  - `empty`=0 and `busy`=1 after edge k.
  - The pop occurs at edge k+1, with `tx` falling to 0 after edge k+1.
  - The stop bit ends after edge k+1+10·CLKS_PER_BIT.
- A write during STOP of the current frame is popped in the following IDLE cycle; no extra gap is added.
- Blocking-OUT integration: the CPU stalls OUT on `full` (buffered mode) or on `busy` (fully blocking mode). This block never asserts back-pressure by itself.

## Test plan
- Single byte, CLKS_PER_BIT=4: `wr`=1 with `din`=0xA5 for one edge.
  - Expect `tx` low 4 cycles (start), then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
  - `busy` falls after 41 cycles from the write edge; `level` goes 1→0 at the pop edge.
- Burst: write 0x01, 0x02, 0x03, 0x04 on consecutive edges.
  - Expect `level` to peak at 3.
  - Four frames decode in order, with frame starts exactly 41 cycles apart and each frame preceded by 1 idle-high cycle.
  - `overflow` stays 0.
- Overflow: write 6 bytes on consecutive edges (0x10..0x15).
  - 0x10 is popped to the transmitter; 0x11..0x14 fill the FIFO and `full`=1.
  - 0x15 is dropped and `overflow`=1.
  - The line carries 0x10..0x14 only; `overflow` stays 1 until rst.
- Wrap-around: with the FIFO refilled to 4 entries after 3 pops, verify pointer wrap. Exactly 4 writes then 4 pops repeated twice must emit all 8 bytes in order.
- Reset mid-frame: assert rst for one edge during DATA bit 3 with 2 bytes queued.
  - Expect `tx`=1, `level`=0, `empty`=1 and `busy`=0 after the edge.
  - No further frames; a subsequent write of 0x5A transmits cleanly.
- Simultaneous write and pop on an edge where `level`=2: `level` stays 2 and both bytes are later transmitted in order.
